commit_queue: RTL and testbench
===============================

// Module: commit_queue
// PURPOSE
// - In-order retirement buffer feeding the commit stage: issue pushes decoded scoreboard entries at the tail,
//   functional units write results back out of order by transaction id, commit stage pops from the head.
// - Drives commit_instr_o/consumes commit_ack_i: the producer end of the commit interface.
// - Entry .valid on the commit side means "completed"; occupancy is tracked internally.
// PARAMETERS
// - NR_ENTRIES       8  queue depth, power of two >= 4; trans_id = slot index (TRANS_ID_BITS = $clog2(NR_ENTRIES))
// - NR_COMMIT_PORTS  2  head entries presented per cycle (1 or 2)
// - NR_WB_PORTS      4  independent writeback ports
// PORTS
// - clk_i             in   1                        clock
// - rst_ni            in   1                        asynchronous active-low reset
// - flush_i           in   1                        discard all entries (mispredict/exception)
// - issue_valid_i     in   1                        new decoded instruction
// - issue_instr_i     in   scoreboard_entry_t       entry to enqueue (.valid ignored)
// - issue_ready_o     out  1                        free slot available
// - issue_trans_id_o  out  TRANS_ID_BITS            slot id assigned to the current issue
// - wb_valid_i        in   NR_WB_PORTS              writeback strobes
// - wb_trans_id_i     in   NR_WB_PORTS x TRANS_ID_BITS  target slot per port
// - wb_result_i       in   NR_WB_PORTS x XLEN       result data
// - wb_ex_i           in   NR_WB_PORTS x exception_t  exception raised by the FU
// - commit_instr_o    out  NR_COMMIT_PORTS x scoreboard_entry_t  head, head+1
// - commit_ack_i      in   NR_COMMIT_PORTS          retire strobes from commit stage
// - empty_o           out  1                        no occupied entries
// BEHAVIOUR
// - State: per-slot occupied/done bits + entry payload; head/tail pointers TRANS_ID_BITS wide (wrap mod NR_ENTRIES);
//   count register TRANS_ID_BITS+1 wide (0..NR_ENTRIES).
// - Reset: head=tail=count=0, all occupied/done=0; outputs issue_ready_o=1, issue_trans_id_o=0, empty_o=1,
//   commit_instr_o[*].valid=0.
// - Issue: accepted when issue_valid_i & issue_ready_o; issue_ready_o = (count != NR_ENTRIES) from registered count
//   only (no same-cycle commit pass-through). Slot tail written, occupied=1, done=issue_instr_i.ex.valid
//   (pre-faulted entries are immediately retirable); tail++ next cycle. issue_trans_id_o = tail.
// - Writeback: for each port with wb_valid_i and slot occupied at cycle start: result, ex (if ex.valid) stored,
//   done=1, effective next cycle (latency 1 to commit visibility). Writeback to unoccupied slot is dropped.
//   Two ports hitting one slot same cycle: illegal; higher port index wins, assertion flags it.
// - Commit view: commit_instr_o[i] = entry[head+i]; .valid = occupied & done & (i < count).
// - Ack rules: commit_ack_i[1] only legal with commit_ack_i[0]; ack of non-valid port illegal (assert).
//   Popped slots cleared (occupied=done=0); head += popcount(ack); count += issue - popcount(ack).
// - Simultaneous issue+commit at full: issue refused that cycle (ready low), commit proceeds.
// - Simultaneous issue into slot X and writeback to X: writeback dropped (slot not occupied at cycle start).
// - flush_i: next cycle head=tail=count=0, all occupied/done=0; same-cycle issue, writeback, ack ignored.
// - Reset mid-operation: immediate return to reset state regardless of pending writebacks.
// CONFIGURATION
// - COMMIT_QUEUE_WB_BYPASS_EN defined: writeback targeting head/head+1 is forwarded combinationally into
//   commit_instr_o (result, ex, valid=1) in the same cycle; latency 0. Storage update unchanged.
// - Not defined: writeback visible at commit output one cycle later only; no wb->commit combinational path.
// TESTING
// - Reset, 8 issues no wb -> ids 0..7, issue_ready_o=0 after 8th, commit valid=0, empty_o=0.
// - Wb id 1 then id 0 (out of order) -> commit valid[0] only after id 0 done; both visible, ack=2'b11, head=2.
// - Issue with ex.valid=1 cause=2 -> entry valid next cycle without wb, ex.cause=2 on port 0.
// - Fill to 8, ack 2 and issue 1 same cycle -> issue refused; next cycle count=6, ready=1; tail wraps 7->0.
// - flush_i with 5 entries and wb on id 3 same cycle -> count=0, empty_o=1, later issue gets head id.
// - BYPASS_EN: wb id=head result 0xDEAD -> commit_instr_o[0].valid=1, result=0xDEAD same cycle; off: next cycle.

Source files
------------

// File: rtl/commit_queue.sv
// In-order retirement buffer: issue enqueues at tail, FUs write back by slot id, commit pops from head.
// Optional COMMIT_QUEUE_WB_BYPASS_EN forwards same-cycle writebacks to the commit view.
package commit_queue_pkg;
  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [31:0]     pc;
    logic [7:0]      op;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    logic            valid;
    exception_t      ex;
  } scoreboard_entry_t;
endpackage

module commit_queue
  import commit_queue_pkg::*;
#(
  parameter int unsigned NR_ENTRIES      = 8,
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned NR_WB_PORTS     = 4,
  localparam int unsigned TRANS_ID_BITS  = $clog2(NR_ENTRIES)
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         flush_i,
  input  logic                                         issue_valid_i,
  input  scoreboard_entry_t                            issue_instr_i,
  output logic                                         issue_ready_o,
  output logic [TRANS_ID_BITS-1:0]                     issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                       wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]    wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][XLEN-1:0]             wb_result_i,
  input  exception_t [NR_WB_PORTS-1:0]                 wb_ex_i,
  output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]      commit_instr_o,
  input  logic [NR_COMMIT_PORTS-1:0]                   commit_ack_i,
  output logic                                         empty_o
);

  scoreboard_entry_t [NR_ENTRIES-1:0] mem_q, mem_d;
  logic [NR_ENTRIES-1:0]              occ_q, occ_d, done_q, done_d;
  logic [TRANS_ID_BITS-1:0]           head_q, head_d, tail_q, tail_d;
  logic [TRANS_ID_BITS:0]             count_q, count_d;
  logic [TRANS_ID_BITS:0]             n_ack;
  logic                               issue_fire;

  assign issue_ready_o    = (count_q != (TRANS_ID_BITS+1)'(NR_ENTRIES));
  assign issue_fire       = issue_valid_i & issue_ready_o;
  assign issue_trans_id_o = tail_q;
  assign empty_o          = (count_q == '0);

  always_comb begin
    n_ack = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      n_ack = n_ack + {{TRANS_ID_BITS{1'b0}}, commit_ack_i[i]};
    end
  end

  always_comb begin
    logic [TRANS_ID_BITS-1:0] slot;
    slot    = '0;
    mem_d   = mem_q;
    occ_d   = occ_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      occ_d   = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Ascending port order lets the highest-indexed port win a (illegal) slot collision.
      for (int w = 0; w < NR_WB_PORTS; w++) begin
        if (wb_valid_i[w] && occ_q[wb_trans_id_i[w]]) begin
          mem_d[wb_trans_id_i[w]].result = wb_result_i[w];
          if (wb_ex_i[w].valid) mem_d[wb_trans_id_i[w]].ex = wb_ex_i[w];
          done_d[wb_trans_id_i[w]] = 1'b1;
        end
      end
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
        if (commit_ack_i[i]) begin
          slot         = head_q + TRANS_ID_BITS'(i);
          occ_d[slot]  = 1'b0;
          done_d[slot] = 1'b0;
        end
      end
      if (issue_fire) begin
        mem_d[tail_q]       = issue_instr_i;
        mem_d[tail_q].valid = 1'b0;
        occ_d[tail_q]       = 1'b1;
        done_d[tail_q]      = issue_instr_i.ex.valid;
      end
      head_d  = head_q + n_ack[TRANS_ID_BITS-1:0];
      tail_d  = tail_q + TRANS_ID_BITS'(issue_fire);
      count_d = count_q + (TRANS_ID_BITS+1)'(issue_fire) - n_ack;
    end
  end

  always_comb begin
    logic [TRANS_ID_BITS-1:0] idx;
    logic                     live;
    idx  = '0;
    live = 1'b0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      idx  = head_q + TRANS_ID_BITS'(i);
      live = occ_q[idx] & (count_q > (TRANS_ID_BITS+1)'(i));
      commit_instr_o[i]       = mem_q[idx];
      commit_instr_o[i].valid = live & done_q[idx];
`ifdef COMMIT_QUEUE_WB_BYPASS_EN
      for (int w = 0; w < NR_WB_PORTS; w++) begin
        if (live && wb_valid_i[w] && (wb_trans_id_i[w] == idx)) begin
          commit_instr_o[i].result = wb_result_i[w];
          if (wb_ex_i[w].valid) commit_instr_o[i].ex = wb_ex_i[w];
          commit_instr_o[i].valid = 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '0;
      occ_q   <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      occ_q   <= occ_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  for (genvar a = 0; a < NR_WB_PORTS; a++) begin : g_wb_chk
    for (genvar b = a + 1; b < NR_WB_PORTS; b++) begin : g_pair
      assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(wb_valid_i[a] && wb_valid_i[b] && (wb_trans_id_i[a] == wb_trans_id_i[b])));
    end
  end

  for (genvar i = 0; i < NR_COMMIT_PORTS; i++) begin : g_ack_chk
    assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
      commit_ack_i[i] |-> commit_instr_o[i].valid);
  end

  if (NR_COMMIT_PORTS > 1) begin : g_ack_order
    assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
      commit_ack_i[1] |-> commit_ack_i[0]);
  end

endmodule

// File: tb/tb_commit_queue.sv
// Randomized bench for commit_queue against an in-order queue reference model.
module tb_commit_queue;
  import commit_queue_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned NC = 2;
  localparam int unsigned NW = 4;
  localparam int unsigned TB = 3;

  logic                        clk = 1'b0;
  logic                        rst_ni = 1'b0;
  logic                        flush;
  logic                        issue_valid;
  scoreboard_entry_t           issue_instr;
  logic                        issue_ready;
  logic [TB-1:0]               issue_trans_id;
  logic [NW-1:0]               wb_valid;
  logic [NW-1:0][TB-1:0]       wb_trans_id;
  logic [NW-1:0][XLEN-1:0]     wb_result;
  exception_t [NW-1:0]         wb_ex;
  scoreboard_entry_t [NC-1:0]  commit_instr;
  logic [NC-1:0]               commit_ack;
  logic                        empty;

  commit_queue #(.NR_ENTRIES(N), .NR_COMMIT_PORTS(NC), .NR_WB_PORTS(NW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_instr_i(issue_instr), .issue_ready_o(issue_ready),
    .issue_trans_id_o(issue_trans_id),
    .wb_valid_i(wb_valid), .wb_trans_id_i(wb_trans_id), .wb_result_i(wb_result), .wb_ex_i(wb_ex),
    .commit_instr_o(commit_instr), .commit_ack_i(commit_ack), .empty_o(empty)
  );

  always #5 clk = ~clk;

  // Reference model: program-ordered list of in-flight instructions.
  typedef struct {
    int unsigned       id;
    scoreboard_entry_t e;
    bit                done;
  } ment_t;

  ment_t       mq[$];
  int unsigned m_head;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_instr = '0;
    wb_valid    = '0;
    wb_trans_id = '0;
    wb_result   = '0;
    wb_ex       = '0;
    commit_ack  = '0;
  endtask

  function automatic scoreboard_entry_t rand_entry(input bit fault);
    scoreboard_entry_t e;
    e.pc       = $urandom;
    e.op       = 8'($urandom);
    e.rd       = 5'($urandom);
    e.result   = $urandom;
    e.valid    = 1'($urandom);
    e.ex.cause = XLEN'($urandom_range(0, 15));
    e.ex.valid = fault;
    return e;
  endfunction

  // Expected commit port i given the model and the currently driven writebacks.
  function automatic void exp_port(input int i, output bit v, output scoreboard_entry_t e);
    v = 1'b0;
    e = '0;
    if (i < mq.size()) begin
      e = mq[i].e;
      v = mq[i].done;
`ifdef COMMIT_QUEUE_WB_BYPASS_EN
      for (int w = 0; w < NW; w++) begin
        if (wb_valid[w] && (int'(wb_trans_id[w]) == int'(mq[i].id))) begin
          e.result = wb_result[w];
          if (wb_ex[w].valid) e.ex = wb_ex[w];
          v = 1'b1;
        end
      end
`endif
      e.valid = v;
    end
  endfunction

  task automatic check_outputs(input string tag);
    bit                v;
    scoreboard_entry_t e;
    check({tag, ".ready"}, 128'(issue_ready), 128'(mq.size() < N));
    check({tag, ".tid"}, 128'(issue_trans_id), 128'((m_head + mq.size()) % N));
    check({tag, ".empty"}, 128'(empty), 128'(mq.size() == 0));
    for (int i = 0; i < NC; i++) begin
      exp_port(i, v, e);
      check($sformatf("%s.valid%0d", tag, i), 128'(commit_instr[i].valid), 128'(v));
      if (v) check($sformatf("%s.entry%0d", tag, i), 128'(commit_instr[i]), 128'(e));
    end
  endtask

  task automatic model_update(input logic iv, input scoreboard_entry_t ie, input logic [NC-1:0] ack,
                              input logic fl);
    bit    rdy;
    ment_t m;
    rdy = mq.size() < N;
    if (fl) begin
      mq.delete();
      m_head = 0;
      return;
    end
    for (int w = 0; w < NW; w++) begin
      if (wb_valid[w]) begin
        foreach (mq[k]) begin
          if (int'(mq[k].id) == int'(wb_trans_id[w])) begin
            mq[k].e.result = wb_result[w];
            if (wb_ex[w].valid) mq[k].e.ex = wb_ex[w];
            mq[k].done = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < NC; i++) begin
      if (ack[i]) begin
        void'(mq.pop_front());
        m_head = (m_head + 1) % N;
      end
    end
    if (iv && rdy) begin
      m.id      = (m_head + mq.size()) % N;
      m.e       = ie;
      m.e.valid = 1'b0;
      m.done    = ie.ex.valid;
      mq.push_back(m);
    end
  endtask

  // One clock: drive at negedge, check settled outputs, advance the model with the posedge.
  task automatic cycle(input string tag, input logic iv, input scoreboard_entry_t ie,
                       input logic [NW-1:0] wv, input logic [NW-1:0][TB-1:0] wid,
                       input logic [NW-1:0][XLEN-1:0] wr, input exception_t [NW-1:0] we,
                       input logic [NC-1:0] ack_req, input logic fl);
    bit                v;
    scoreboard_entry_t e;
    logic [NC-1:0]     ack;
    issue_valid = iv;
    issue_instr = ie;
    wb_valid    = wv;
    wb_trans_id = wid;
    wb_result   = wr;
    wb_ex       = we;
    flush       = fl;
    #1;
    ack = '0;
    exp_port(0, v, e);
    if (ack_req[0] && v) ack[0] = 1'b1;
    exp_port(1, v, e);
    if (ack[0] && ack_req[1] && v) ack[1] = 1'b1;
    commit_ack = ack;
    #1;
    check_outputs(tag);
    model_update(iv, ie, ack, fl);
    @(posedge clk);
    #1;
    drive_idle();
    @(negedge clk);
  endtask

  task automatic step(input string tag, input logic iv, input scoreboard_entry_t ie, input int wid,
                      input logic [XLEN-1:0] wres, input logic [NC-1:0] ack, input logic fl);
    logic [NW-1:0]           wv;
    logic [NW-1:0][TB-1:0]   ids;
    logic [NW-1:0][XLEN-1:0] wr;
    exception_t [NW-1:0]     we;
    wv = '0;
    ids = '0;
    wr = '0;
    we = '0;
    if (wid >= 0) begin
      wv[2]  = 1'b1;
      ids[2] = TB'(wid);
      wr[2]  = wres;
    end
    cycle(tag, iv, ie, wv, ids, wr, we, ack, fl);
  endtask

  task automatic do_reset();
    #2 rst_ni = 1'b0;
    #1;
    mq.delete();
    m_head = 0;
    check_outputs("rst");
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    scoreboard_entry_t e;
    drive_idle();
    m_head = 0;
    repeat (2) @(negedge clk);
    check("reset.ready", 128'(issue_ready), 128'(1));
    check("reset.tid", 128'(issue_trans_id), 128'(0));
    check("reset.empty", 128'(empty), 128'(1));
    check("reset.valid", 128'({commit_instr[1].valid, commit_instr[0].valid}), 128'(0));
    rst_ni = 1'b1;
    @(negedge clk);

    // Fill with 8 entries, no writebacks.
    for (int i = 0; i < 8; i++) step("fill", 1'b1, rand_entry(1'b0), -1, '0, '0, 1'b0);
    check("full.ready", 128'(issue_ready), 128'(0));
    check("full.empty", 128'(empty), 128'(0));
    check("full.valid", 128'({commit_instr[1].valid, commit_instr[0].valid}), 128'(0));
    // Out-of-order completion, then retire two while an issue is refused at full.
    step("wb1", 1'b0, '0, 1, 32'h1111, '0, 1'b0);
    check("wb1.valid0", 128'(commit_instr[0].valid), 128'(0));
    step("wb0", 1'b0, '0, 0, 32'h2222, '0, 1'b0);
    check("wb0.valid", 128'({commit_instr[1].valid, commit_instr[0].valid}), 128'(2'b11));
    step("ackfull", 1'b1, rand_entry(1'b0), -1, '0, 2'b11, 1'b0);
    check("ack.ready", 128'(issue_ready), 128'(1));
    check("ack.tid_wrap", 128'(issue_trans_id), 128'(0));
    step("wrap", 1'b1, rand_entry(1'b0), -1, '0, '0, 1'b0);
    check("wrap.tid", 128'(issue_trans_id), 128'(1));

    // Pre-faulted issue retires without writeback.
    step("flush0", 1'b0, '0, -1, '0, '0, 1'b1);
    e = rand_entry(1'b1);
    e.ex.cause = 2;
    step("fault", 1'b1, e, -1, '0, '0, 1'b0);
    check("fault.valid", 128'(commit_instr[0].valid), 128'(1));
    check("fault.cause", 128'(commit_instr[0].ex.cause), 128'(2));

    // Flush with 5 entries and a same-cycle writeback.
    step("flush1", 1'b0, '0, -1, '0, '0, 1'b1);
    for (int i = 0; i < 5; i++) step("five", 1'b1, rand_entry(1'b0), -1, '0, '0, 1'b0);
    step("flushwb", 1'b1, rand_entry(1'b0), 3, 32'h3333, '0, 1'b1);
    check("flush.empty", 128'(empty), 128'(1));
    check("flush.tid", 128'(issue_trans_id), 128'(0));

    // Writeback to head: same-cycle visibility only with bypass (checked inside the step).
    step("byp_iss", 1'b1, rand_entry(1'b0), -1, '0, '0, 1'b0);
    step("byp_wb", 1'b0, '0, 0, 32'hDEAD, '0, 1'b0);
    check("byp.valid", 128'(commit_instr[0].valid), 128'(1));
    check("byp.result", 128'(commit_instr[0].result), 128'(32'hDEAD));

    // Random traffic with a mid-run asynchronous reset.
    for (int c = 0; c < 3000; c++) begin
      logic [NW-1:0]           wv;
      logic [NW-1:0][TB-1:0]   wid;
      logic [NW-1:0][XLEN-1:0] wr;
      exception_t [NW-1:0]     we;
      for (int w = 0; w < NW; w++) begin
        wv[w]        = 1'($urandom_range(0, 1));
        wid[w]       = TB'((m_head + $urandom_range(0, N - 1)) % N);
        wr[w]        = $urandom;
        we[w].cause  = XLEN'($urandom_range(0, 15));
        we[w].valid  = ($urandom_range(0, 7) == 0);
      end
      for (int w = 1; w < NW; w++)
        for (int k = 0; k < w; k++)
          if (wv[k] && wv[w] && (wid[k] == wid[w])) wv[w] = 1'b0;
      cycle("rand", ($urandom_range(0, 3) != 0), rand_entry($urandom_range(0, 7) == 0), wv, wid,
            wr, we, NC'($urandom), ($urandom_range(0, 63) == 0));
      if (c == 1500) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
